// File: rtl/ifft16_dif_radix2_pkg.sv
// ifft16_pkg: shared state type, twiddle tables and index helper for the 16-point IFFT
package ifft16_pkg;
    typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_t;
    localparam int N = 16;
    localparam int COS_Q [0:7] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137};
    localparam int SIN_Q [0:7] = '{0, 6270, 11585, 15137, 16384, 15137, 11585, 6270};
    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction
endpackage

// File: rtl/ifft16_dif_radix2_if.sv
// ifft16_dif_radix2_if: sample-in / sample-out streaming handshake bundle
interface ifft16_dif_radix2_if #(parameter int WIDTH = 16);
    logic signed [WIDTH-1:0] in_real, in_image;
    logic in_valid, in_ready;
    logic signed [WIDTH:0] out_real, out_image;
    logic out_valid, out_ready, out_last, busy;
    modport slave (
        input in_real, in_image, in_valid, out_ready,
        output in_ready, out_real, out_image, out_valid, out_last, busy
    );
    modport master (
        output in_real, in_image, in_valid, out_ready,
        input in_ready, out_real, out_image, out_valid, out_last, busy
    );
endinterface

// File: rtl/ifft16_dif_radix2_bfly.sv
// ifft_bfly: DIF butterfly, sum path plus difference rotated by conj(W) with round-half-up
module ifft_bfly #(
    parameter int D = 22,
    parameter int TW_W = 16
) (
    input logic signed [D-1:0] a_re_i, a_im_i, b_re_i, b_im_i,
    input logic signed [TW_W-1:0] cos_i, sin_i,
    output logic signed [D-1:0] y0_re_o, y0_im_o, y1_re_o, y1_im_o
);
    localparam int P = D + TW_W + 1;
    localparam logic signed [P-1:0] RND = P'(1) <<< (TW_W - 3);
    logic signed [P-1:0] d_re, d_im, p_re, p_im;
    // (a-b)*(cos + j*sin) kept at full precision, rounded once per component
    always_comb begin
        y0_re_o = a_re_i + b_re_i;
        y0_im_o = a_im_i + b_im_i;
        d_re = P'(a_re_i) - P'(b_re_i);
        d_im = P'(a_im_i) - P'(b_im_i);
        p_re = d_re * P'(cos_i) - d_im * P'(sin_i) + RND;
        p_im = d_re * P'(sin_i) + d_im * P'(cos_i) + RND;
        y1_re_o = D'(p_re >>> (TW_W - 2));
        y1_im_o = D'(p_im >>> (TW_W - 2));
    end
endmodule

// File: rtl/ifft16_dif_radix2.sv
// ifft16_dif_radix2: in-place 16-point radix-2 DIF inverse FFT, one stage per cycle
module ifft16_dif_radix2
    import ifft16_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int TW_W = 16
) (
    input logic clk,
    input logic rst,
    ifft16_dif_radix2_if.slave io
);
    localparam int D = WIDTH + 6;
    state_t state_q;
    logic [3:0] wr_cnt_q, rd_cnt_q;
    logic [1:0] stage_q;
    logic valid_q, last_q;
    logic signed [WIDTH:0] ore_q, oim_q;
    logic signed [D-1:0] re_q [N], im_q [N];
    logic [3:0] ia [8], ib [8];
    logic signed [TW_W-1:0] tc [8], ts [8];
    logic signed [D-1:0] y0_re [8], y0_im [8], y1_re [8], y1_im [8];
    logic signed [D-1:0] sel_re, sel_im;
    logic in_fire, done, fetch;
    int sp;

    assign io.in_ready = state_q == LOAD;
    assign io.busy = state_q != LOAD;
    assign io.out_valid = valid_q;
    assign io.out_last = last_q;
    assign io.out_real = ore_q;
    assign io.out_image = oim_q;
    assign in_fire = state_q == LOAD && io.in_valid;
    assign done = valid_q && last_q && io.out_ready;
    assign fetch = state_q == UNLOAD && (!valid_q || io.out_ready) && !(valid_q && last_q);
    assign sel_re = re_q[bitrev4(rd_cnt_q)] + D'(8);
    assign sel_im = im_q[bitrev4(rd_cnt_q)] + D'(8);

    // butterfly j of stage s pairs i = 2j - k with i + span, k = j mod span, twiddle k*2^s
    always_comb begin
        sp = 8 >> stage_q;
        for (int j = 0; j < 8; j++) begin
            ia[j] = 4'(2 * j - (j & (sp - 1)));
            ib[j] = 4'(2 * j - (j & (sp - 1)) + sp);
            tc[j] = TW_W'(COS_Q[3'((j & (sp - 1)) << stage_q)]);
            ts[j] = TW_W'(SIN_Q[3'((j & (sp - 1)) << stage_q)]);
        end
    end

    for (genvar g = 0; g < 8; g++) begin : g_bfly
        ifft_bfly #(.D(D), .TW_W(TW_W)) u_bfly (
            .a_re_i(re_q[ia[g]]), .a_im_i(im_q[ia[g]]),
            .b_re_i(re_q[ib[g]]), .b_im_i(im_q[ib[g]]),
            .cos_i(tc[g]), .sin_i(ts[g]),
            .y0_re_o(y0_re[g]), .y0_im_o(y0_im[g]),
            .y1_re_o(y1_re[g]), .y1_im_o(y1_im[g])
        );
    end

    // sample buffer: written by input beats in LOAD and by a whole stage per CALC cycle
    always_ff @(posedge clk) begin
        if (in_fire) begin
            re_q[wr_cnt_q] <= D'(io.in_real);
            im_q[wr_cnt_q] <= D'(io.in_image);
        end else if (state_q == CALC) begin
            for (int j = 0; j < 8; j++) begin
                re_q[ia[j]] <= y0_re[j];
                im_q[ia[j]] <= y0_im[j];
                re_q[ib[j]] <= y1_re[j];
                im_q[ib[j]] <= y1_im[j];
            end
        end
    end

    // control FSM; UNLOAD primes the output register one cycle before the first beat
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            stage_q <= '0;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            ore_q <= '0;
            oim_q <= '0;
        end else begin
            case (state_q)
                LOAD: if (in_fire) begin
                    wr_cnt_q <= wr_cnt_q + 4'd1;
                    if (wr_cnt_q == 4'd15) state_q <= CALC;
                end
                CALC: begin
                    stage_q <= stage_q + 2'd1;
                    if (stage_q == 2'd3) state_q <= UNLOAD;
                end
                default: if (done) begin
                    state_q <= LOAD;
                    valid_q <= 1'b0;
                    last_q <= 1'b0;
                    rd_cnt_q <= '0;
                end else if (fetch) begin
                    valid_q <= 1'b1;
                    last_q <= rd_cnt_q == 4'd15;
                    ore_q <= (WIDTH + 1)'(sel_re >>> 4);
                    oim_q <= (WIDTH + 1)'(sel_im >>> 4);
                    rd_cnt_q <= rd_cnt_q + 4'd1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifft16_dif_radix2.sv
// tb_ifft16_dif_radix2: randomized frames checked against a floating-point inverse DFT
`timescale 1ns/1ps
module tb_ifft16_dif_radix2;
    typedef int frame_t [16];
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;

    ifft16_dif_radix2_if #(.WIDTH(16)) bus ();
    ifft16_dif_radix2 #(.WIDTH(16), .TW_W(16)) dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
        n_vec++;
        if (got > exp + tol || got < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic void idft(input frame_t xr, input frame_t xi, output frame_t er, output frame_t ei);
        real sr, si, th;
        for (int n = 0; n < 16; n++) begin
            sr = 0.0;
            si = 0.0;
            for (int k = 0; k < 16; k++) begin
                th = 2.0 * 3.14159265358979 * real'(n * k) / 16.0;
                sr += real'(xr[k]) * $cos(th) - real'(xi[k]) * $sin(th);
                si += real'(xr[k]) * $sin(th) + real'(xi[k]) * $cos(th);
            end
            er[n] = int'(sr / 16.0);
            ei[n] = int'(si / 16.0);
        end
    endfunction

    task automatic drive(input frame_t xr, input frame_t xi, input bit gaps);
        int i = 0;
        int cyc = 0;
        while (i < 16 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_real = 16'(xr[i]);
            bus.in_image = 16'(xi[i]);
            if (bus.in_valid && bus.in_ready) i++;
        end
        if (i < 16) chk("in_timeout", i, 16);
    endtask

    task automatic collect(input bit bp, output frame_t gr, output frame_t gi);
        int n = 0;
        int cyc = 0;
        int first = -1;
        int hr = 0;
        int hi = 0;
        int hl = 0;
        bit held = 1'b0;
        bit rdy;
        gr = '{default: 0};
        gi = '{default: 0};
        while (n < 16 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = 1'b0;
            chk("in_ready_busy", int'(bus.in_ready), 0);
            chk("busy", int'(bus.busy), 1);
            if (held) begin
                chk("hold_re", bus.out_real, hr);
                chk("hold_im", bus.out_image, hi);
                chk("hold_last", int'(bus.out_last), hl);
            end
            if (bus.out_valid && first < 0) first = cyc;
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            held = bus.out_valid && !rdy;
            hr = bus.out_real;
            hi = bus.out_image;
            hl = int'(bus.out_last);
            if (bus.out_valid && rdy) begin
                gr[n] = bus.out_real;
                gi[n] = bus.out_image;
                chk("out_last", int'(bus.out_last), int'(n == 15));
                n++;
            end
        end
        if (n < 16) chk("out_timeout", n, 16);
        chk("latency", first, 6);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("reload_in_ready", int'(bus.in_ready), 1);
        chk("reload_out_valid", int'(bus.out_valid), 0);
        chk("reload_busy", int'(bus.busy), 0);
    endtask

    task automatic run(input frame_t xr, input frame_t xi, input bit gaps, input bit bp, input int tol, input string tag);
        frame_t er, ei, gr, gi;
        idft(xr, xi, er, ei);
        drive(xr, xi, gaps);
        collect(bp, gr, gi);
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("%s_re%0d", tag, n), gr[n], er[n], tol);
            chk($sformatf("%s_im%0d", tag, n), gi[n], ei[n], tol);
        end
    endtask

    initial begin
        frame_t xr, xi;
        bus.in_valid = 1'b0;
        bus.in_real = '0;
        bus.in_image = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_out_re", bus.out_real, 0);
        chk("rst_out_im", bus.out_image, 0);
        rst = 1'b0;

        xr = '{default: 0};
        xi = '{default: 0};
        xr[0] = 16;
        run(xr, xi, 1'b0, 1'b0, 0, "impulse");

        xr[0] = 0;
        xr[4] = 16;
        run(xr, xi, 1'b0, 1'b0, 0, "bin4");

        xr = '{default: 32767};
        xi = '{default: 32767};
        run(xr, xi, 1'b0, 1'b1, 1, "extreme");

        for (int f = 0; f < 200; f++) begin
            for (int k = 0; k < 16; k++) begin
                xr[k] = int'($urandom_range(0, 8190)) - 4095;
                xi[k] = int'($urandom_range(0, 8190)) - 4095;
            end
            run(xr, xi, f[0], f[0], 1, "rand");
        end

        xr = '{default: 0};
        xi = '{default: 0};
        xr[0] = 16;
        drive(xr, xi, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready", int'(bus.in_ready), 1);
        chk("midrst_out_valid", int'(bus.out_valid), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_out_re", bus.out_real, 0);
        repeat (8) begin
            @(negedge clk);
            chk("midrst_idle_valid", int'(bus.out_valid), 0);
        end
        run(xr, xi, 1'b0, 1'b0, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
